// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reverse scheduler.
package bitrev_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } bitrev_state_e;

    localparam int unsigned DATA_W_DEF = 8;

    // Round-robin pick: first set bit of valid[0 +: n] searching from last+1 with wrap.
    // Returns last when nothing is valid; callers only use the result when a bit is set.
    function automatic int rr_pick(input logic [31:0] valid, input int last, input int n);
        int idx;
        rr_pick = last;
        // Walk offsets from farthest to nearest so the nearest valid index wins.
        for (int k = n; k >= 1; k--) begin
            idx = (last + k) % n;
            if (valid[idx[4:0]]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // Golden reversal: out[i] = in[DATA_W_DEF-1-i].
    function automatic logic [DATA_W_DEF-1:0] bit_reverse(input logic [DATA_W_DEF-1:0] data);
        for (int i = 0; i < int'(DATA_W_DEF); i++) begin
            bit_reverse[i] = data[int'(DATA_W_DEF) - 1 - i];
        end
    endfunction

endpackage

// File: rtl/bitrev_serial.sv
// Serial bit-reverse engine: one operand bit moves into the result per cycle.
module bitrev_serial
    import bitrev_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  cnt;
    logic              running;

    // High during the final shift cycle; the edge that completes it enters RESP.
    assign done = running && (cnt == CNT_W'(DATA_W - 1));
    assign dout = result;

    // Load on start, then shift LSB-first from src into the result's LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src     <= '0;
            result  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            src     <= din;
            result  <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            result <= (result << 1) | DATA_W'(src[0]);
            src    <= src >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bitrev_sched.sv
// Round-robin scheduler sharing one serial bit-reverse engine among NUM_REQ requesters.
module bitrev_sched
    import bitrev_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    output logic                      busy
);

    bitrev_state_e     state_q, state_d;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   id_q;
    int                grant_idx;
    logic [DATA_W-1:0] operand;
    logic              start;
    logic              done;

    // Winner of the current arbitration round and its operand.
    always_comb begin
        grant_idx = rr_pick(32'(req_valid), int'(last_grant), int'(NUM_REQ));
        operand   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (i == grant_idx) begin
                operand = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state and the one-hot accept strobe, which exists only in IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        req_ready[i] = (i == grant_idx);
                    end
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and response tag; reset makes requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                last_grant <= ID_W'(grant_idx);
                id_q       <= ID_W'(grant_idx);
            end
        end
    end

    bitrev_serial #(
        .DATA_W (DATA_W)
    ) u_serial (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (operand),
        .done  (done),
        .dout  (rsp_data)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule
